// File: rtl/bcast_pkg.sv
// Shared types and default sizes for the broadcast tracker arbiter.
package bcast_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_TRACKERS = 4;
    localparam int DEF_LINE_W       = 27;

endpackage

// File: rtl/broadcast_tracker_arbiter_if.sv
// Inbound A channel plus per-tracker status/steering bundle for the arbiter.
interface broadcast_tracker_arbiter_if import bcast_pkg::*; #(
    parameter int NUM_TRACKERS = DEF_NUM_TRACKERS,
    parameter int LINE_W       = DEF_LINE_W
) ();

    // A beat transfers on a rising clock edge where in_a_valid and in_a_ready are
    // both high; valid may not depend on ready, and a beat is held until accepted.
    logic                           in_a_valid;
    logic                           in_a_ready;
    logic                           in_a_first;
    logic                           in_a_last;
    logic [LINE_W-1:0]              in_a_line;
    logic [NUM_TRACKERS-1:0]        trk_idle;
    logic [NUM_TRACKERS*LINE_W-1:0] trk_line;
    logic [NUM_TRACKERS-1:0]        trk_ready;
    logic [NUM_TRACKERS-1:0]        trk_valid;
    logic                           busy;
    logic                           conflict;

    modport master (
        output in_a_valid, in_a_first, in_a_last, in_a_line,
        output trk_idle, trk_line, trk_ready,
        input  in_a_ready, trk_valid, busy, conflict
    );

    modport slave (
        input  in_a_valid, in_a_first, in_a_last, in_a_line,
        input  trk_idle, trk_line, trk_ready,
        output in_a_ready, trk_valid, busy, conflict
    );

endinterface

// File: rtl/bcast_idle_picker.sv
// Rotating first-one finder: first set bit of req at or after start, wrapping.
module bcast_idle_picker import bcast_pkg::*; #(
    parameter  int N  = DEF_NUM_TRACKERS,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/broadcast_tracker_arbiter.sv
// Steers inbound A messages to an idle broadcast tracker, locking the choice for a burst.
// Optional BCAST_ARB_ROUND_ROBIN_EN rotates the search start; otherwise lowest index wins.
module broadcast_tracker_arbiter import bcast_pkg::*; #(
    parameter int NUM_TRACKERS = DEF_NUM_TRACKERS,
    parameter int LINE_W       = DEF_LINE_W
) (
    input  logic                        clock,
    input  logic                        reset,
    broadcast_tracker_arbiter_if.slave  bus,
    output arb_state_e                  state_dbg
);

    localparam int PW = (NUM_TRACKERS > 1) ? $clog2(NUM_TRACKERS) : 1;

    arb_state_e              state, state_next;
    logic [PW-1:0]           locked, locked_next;
    logic [PW-1:0]           cand;
    logic [PW-1:0]           start_ptr;
    logic                    found;
    logic                    hazard;
    logic                    sel_ok;
    logic                    ready_c;
    logic                    conflict_c;
    logic [NUM_TRACKERS-1:0] valid_c;

    // A line still owned by a working tracker blocks a new first beat to that line.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_TRACKERS; i++) begin
            if (!bus.trk_idle[i] && (bus.trk_line[i*LINE_W +: LINE_W] == bus.in_a_line))
                hazard = 1'b1;
        end
    end

    bcast_idle_picker #(.N(NUM_TRACKERS)) u_picker (
        .req   (bus.trk_idle),
        .start (start_ptr),
        .idx   (cand),
        .found (found)
    );

    assign sel_ok = bus.in_a_valid & bus.in_a_first & ~hazard & found;

`ifdef BCAST_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] rr_ptr;
    logic          first_accept;

    assign start_ptr    = rr_ptr;
    assign first_accept = (state == IDLE) & sel_ok & bus.trk_ready[cand];

    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (first_accept)
            rr_ptr <= (cand == PW'(NUM_TRACKERS - 1)) ? '0 : cand + PW'(1);
    end
`else
    assign start_ptr = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            locked <= '0;
        end else begin
            state  <= state_next;
            locked <= locked_next;
        end
    end

    always_comb begin
        state_next  = state;
        locked_next = locked;
        valid_c     = '0;
        ready_c     = 1'b0;
        conflict_c  = 1'b0;
        case (state)
            IDLE: begin
                conflict_c = bus.in_a_valid & bus.in_a_first & hazard;
                if (sel_ok) begin
                    valid_c = NUM_TRACKERS'(1) << cand;
                    ready_c = bus.trk_ready[cand];
                    if (ready_c && !bus.in_a_last) begin
                        state_next  = BURST;
                        locked_next = cand;
                    end
                end
            end
            BURST: begin
                valid_c = bus.in_a_valid ? (NUM_TRACKERS'(1) << locked) : '0;
                ready_c = bus.trk_ready[locked];
                if (bus.in_a_valid && ready_c && bus.in_a_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.trk_valid  = valid_c;
    assign bus.in_a_ready = ready_c;
    assign bus.conflict   = conflict_c;
    assign bus.busy       = (state == BURST);
    assign state_dbg      = state;

`ifndef SYNTHESIS
    a_onehot_valid: assert property (@(posedge clock) disable iff (reset)
        $onehot0(bus.trk_valid));
    a_no_first_in_burst: assert property (@(posedge clock) disable iff (reset)
        (state == BURST && bus.in_a_valid) |-> !bus.in_a_first);
`endif

endmodule

// File: doc/broadcast_tracker_arbiter.md
BROADCAST_TRACKER_ARBITER -- requirements
Module: broadcast_tracker_arbiter

Interface
REQ-001 Parameters SHALL be NUM_TRACKERS, default 4, number of broadcast trackers arbitrated (2..16).
REQ-002 Parameters SHALL include LINE_W, default 27, cache-line address width (address[32:6]).
REQ-003 Ports SHALL be: clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 in_a_valid  in  1  inbound A beat valid.
REQ-005 in_a_ready  out  1  inbound A beat accepted.
REQ-006 in_a_first / in_a_last  in  1 each  beat is first / last of its message.
REQ-007 in_a_line  in  LINE_W  line address of the inbound message, valid with in_a_first.
REQ-008 trk_idle  in  NUM_TRACKERS  per-tracker idle (got_e and sent_d).
REQ-009 trk_line  in  NUM_TRACKERS*LINE_W  per-tracker held line, tracker i at slice i.
REQ-010 trk_ready  in  NUM_TRACKERS  per-tracker inbound A ready.
REQ-011 trk_valid  out  NUM_TRACKERS  one-hot inbound A valid steering to the chosen tracker.
REQ-012 busy  out  1  mid-burst lock held.
REQ-013 conflict  out  1  first beat stalled by a line hazard this cycle.

Function
REQ-014 Two states SHALL exist: IDLE (no burst in progress) and BURST (selection locked).
REQ-015 In IDLE, hazard = OR over i of (~trk_idle[i] and trk_line[i] == in_a_line); conflict = in_a_valid & in_a_first & hazard.
REQ-016 In IDLE with no hazard, the candidate SHALL be one idle tracker chosen per REQ-027/028; zero-cycle, combinational from inputs and pointer.
REQ-017 In IDLE, trk_valid SHALL be one-hot(candidate) & in_a_valid & in_a_first & ~hazard & any-idle; otherwise all zero.
REQ-018 in_a_ready SHALL equal trk_ready[candidate] in IDLE when trk_valid nonzero, 0 otherwise.
REQ-019 Accepted first beat with in_a_last=0 SHALL register candidate as locked index and move to BURST next cycle; with in_a_last=1 state remains IDLE.
REQ-020 In BURST, trk_valid = one-hot(locked) & in_a_valid, in_a_ready = trk_ready[locked], hazard check disabled, conflict=0.
REQ-021 In BURST, accepted beat with in_a_last=1 SHALL return to IDLE next cycle; in_a_first asserted in BURST is a protocol error (assertion, simulation only).
REQ-022 No idle tracker in IDLE: in_a_ready=0, trk_valid=0, conflict reflects hazard only.
REQ-023 in_a_valid=0 SHALL never change state or pointer.
REQ-024 Matching line in an idle tracker SHALL NOT count as hazard.
REQ-025 busy SHALL be 1 exactly in BURST.
REQ-026 trk_valid SHALL never have more than one bit set (assertion).

Configuration
REQ-027 With BCAST_ARB_ROUND_ROBIN_EN defined: candidate = first idle tracker at or after rr_ptr (wrap modulo NUM_TRACKERS); rr_ptr <= candidate+1 (wrapping) on each accepted first beat.
REQ-028 Without BCAST_ARB_ROUND_ROBIN_EN: candidate = lowest-index idle tracker; no rr_ptr register exists.

Reset
REQ-029 Reset SHALL force state IDLE, locked index 0, rr_ptr 0; outputs after reset: busy=0, trk_valid=0, in_a_ready=0 unless inputs select a tracker, conflict combinational.
REQ-030 Reset mid-burst SHALL abandon the lock; next cycle is IDLE.

Structure
REQ-031 Shared package bcast_pkg SHALL hold arb_state_e (IDLE, BURST), default NUM_TRACKERS and LINE_W constants.
REQ-032 One sub-module bcast_idle_picker (rotating/priority first-one finder, returns index and found flag) SHALL be instantiated once.

Verification
REQ-033 Single-beat Get, all idle, RR on: trk_valid=4'b0001, next Get -> 4'b0010, rr_ptr wraps 3->0.
REQ-034 Tracker 2 busy on line 0x1234, new first beat line 0x1234 -> conflict=1, in_a_ready=0 until trk_idle[2]=1, then accepted.
REQ-035 4-beat PutFull to tracker 1 with trk_ready toggling -> all 4 beats steered to tracker 1, busy=1 beats 2-4, IDLE after last accept.
REQ-036 trk_idle=0 all -> in_a_ready=0 indefinitely; free tracker 3 -> accepted on that cycle, trk_valid=4'b1000.
REQ-037 Reset asserted during beat 2 of burst -> busy=0 next cycle, following first beat re-arbitrated from rr_ptr 0.
REQ-038 RR off, trackers 0 and 2 idle -> tracker 0 chosen every time.
